bell_sched_57: RTL and testbench
================================

# bell_sched_57

Buzzer scheduler that shares the single buzzer among three requesters: live organ keys, alarm melody and hourly chime. It resolves priority, sequences the alarm melody and the chime beep train, and defers or drops requests that collide. It emits a registered tone code for the downstream note-frequency mux and a source tag for the LED and display logic.

## Interface
Parameters:
- NOTE_MS, 250: alarm melody note length, in 1 kHz ticks.
- ALARM_TIMEOUT_S, 60: alarm self-stop time, in 1 Hz ticks.
- BEEP_ON_MS, 200: chime beep on-time, in 1 kHz ticks.
- BEEP_OFF_MS, 300: chime gap, in 1 kHz ticks.
- CHIME_TONE, 4'd6: tone code used for chime beeps (la).

Ports:
- clk_50m_57  in  1  system clock; the block's only clock.
- rst_57  in  1  asynchronous, active-low reset.
- tick_1k_57  in  1  one-cycle enable pulse at 1 kHz.
- tick_1hz_57  in  1  one-cycle enable pulse at 1 Hz.
- bell_e_57  in  1  master buzzer enable (level).
- organ_e_57  in  1  organ mode (level).
- organ_key_57  in  8  debounced organ keys; bit i is note i+1.
- alarm_hit_57  in  1  one-cycle pulse: current time equals stored alarm.
- chime_hit_57  in  1  one-cycle pulse: minute and second are both zero.
- hour_57  in  7  current hour, 0–23, sampled on chime_hit_57.
- key_stop_57  in  1  one-cycle dismiss pulse.
- tone_sel_57  out  4  0 = silent; 1–8 = do, re, mi, fa, so, la, ti, doh.
- src_57  out  2  0 none, 1 organ, 2 alarm, 3 chime.

## Operation
- FSM states: IDLE, ORGAN, ALARM, CHIME_ON, CHIME_OFF.
- Priority: ORGAN > ALARM > CHIME.
- Every output, counter, pending flag and latched value resets to 0; the FSM resets to IDLE.

bell_e_57 low:
- FSM forced to IDLE.
- tone_sel_57 and src_57 are 0.
- Pending flags cleared; incoming hits discarded.

ORGAN:
- Entered from any state while organ_e_57 = 1.
- A running alarm or chime is abandoned; its pending flag is set so it resumes from the start.
- tone_sel_57 = index of the lowest set bit of organ_key_57, plus 1; 0 if no key is pressed.
- Hits arriving during ORGAN set alarm_pend or chime_pend; chime_pend also latches the hour.
- On organ_e_57 falling: go to ALARM if alarm_pend, else to CHIME_ON if chime_pend, else to IDLE.

ALARM:
- Plays an 8-entry melody ROM in a loop; the note index advances after NOTE_MS tick_1k pulses.
- A second counter runs on tick_1hz_57; reaching ALARM_TIMEOUT_S exits the state.
- key_stop_57 or the timeout exits: go to CHIME_ON if chime_pend, else to IDLE.
- A new alarm_hit_57 while in ALARM clears the second counter (timeout restarts); the note index is unchanged.
- A chime_hit_57 while in ALARM sets chime_pend and latches the hour.

Chime:
- Beep count n = hour mod 12, with 0 mapped to 12. Count is 1–12.
- CHIME_ON: tone_sel_57 = CHIME_TONE for BEEP_ON_MS ticks, then CHIME_OFF with tone 0 for BEEP_OFF_MS ticks.
- After the n-th gap, go to IDLE.
- alarm_hit_57 during a chime aborts it (chime dropped, not pended) and enters ALARM.
- key_stop_57 during a chime aborts it and goes to IDLE.
- chime_hit_57 during a chime is ignored.

Simultaneous events:
- alarm_hit_57 and chime_hit_57 in the same cycle from IDLE: ALARM is entered and chime_pend is set.
- key_stop_57 in the same cycle as an alarm_hit_57 that would restart ALARM: stop wins.

## Timing
- All outputs are registered. A request sampled at edge k gives a new state, tone_sel_57 and src_57 after edge k; combinational input-to-output latency is 0.
- ALARM starts at melody[0], with the note counter and second counter cleared on entry.
- Note boundaries count tick_1k pulses only; the clock rate is irrelevant.
- A tick landing on the entry cycle is not counted.
- Chime at hour 13: exactly 1 beep. Total duration = 200 + 300 = 500 ms.
- Reset assertion mid-sequence: outputs go to 0 immediately (asynchronous). Release is synchronous to the next edge.

## Structure
- Package bell_pkg_57 holds:
  - tone codes TONE_OFF and TONE_DO through TONE_DOH;
  - src codes SRC_NONE, SRC_ORGAN, SRC_ALARM, SRC_CHIME;
  - the FSM state enum;
  - the 8-note melody constant {1,3,5,8,5,3,1,0}.
- Sub-module bell_melody_rom_57: 3-bit index in, 4-bit tone out, combinational, reads the package constant.
- Top level holds the FSM, the ms counter (9 bits), the second counter (6 bits), the beep counter (4 bits), pending flags and the latched hour.

## Test plan
- Alarm, then timeout: alarm_hit at IDLE, no stop, 60 tick_1hz → melody 1,3,5,8,5,3,1,0 repeating, each note 250 ticks; src_57 = 2 throughout; IDLE after the 60th second.
- Chime counts: chime_hit with hour = 0, 12 and 15 → 12, 12 and 3 beeps, tone 6 on 200 ticks / off 300 ticks; src_57 = 3; then IDLE.
- Collision: alarm_hit and chime_hit same cycle with hour = 9, then key_stop after 5 s → alarm stops, then exactly 9 beeps.
- Organ preemption: alarm running, organ_e up with organ_key = 8'b0010_0100 → tone 3, src 1; organ_e drops → alarm restarts at melody[0].
- Master mute: bell_e low mid-chime, plus a new alarm_hit → tone 0, src 0; nothing plays after bell_e returns high.
- Async reset: assert rst_57 low mid-ALARM between clock edges → tone_sel_57 = 0 and src_57 = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/bell_pkg_57.sv
// Shared constants for the buzzer scheduler: tone/source codes, FSM states,
// the alarm melody and small decode helpers.
package bell_pkg_57;

  localparam logic [3:0] TONE_OFF = 4'd0;
  localparam logic [3:0] TONE_DO  = 4'd1;
  localparam logic [3:0] TONE_RE  = 4'd2;
  localparam logic [3:0] TONE_MI  = 4'd3;
  localparam logic [3:0] TONE_FA  = 4'd4;
  localparam logic [3:0] TONE_SO  = 4'd5;
  localparam logic [3:0] TONE_LA  = 4'd6;
  localparam logic [3:0] TONE_TI  = 4'd7;
  localparam logic [3:0] TONE_DOH = 4'd8;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_ORGAN = 2'd1;
  localparam logic [1:0] SRC_ALARM = 2'd2;
  localparam logic [1:0] SRC_CHIME = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ORGAN     = 3'd1,
    ST_ALARM     = 3'd2,
    ST_CHIME_ON  = 3'd3,
    ST_CHIME_OFF = 3'd4
  } bell_state_t;

  // Melody entry i lives in bits [4*i+3:4*i]; entry 0 is the first note played.
  localparam logic [31:0] MELODY_57 = {TONE_OFF, TONE_DO, TONE_MI, TONE_SO,
                                       TONE_DOH, TONE_SO, TONE_MI, TONE_DO};

  // Lowest pressed key wins; no key gives silence.
  function automatic logic [3:0] organ_tone(input logic [7:0] keys);
    logic [3:0] t;
    t = TONE_OFF;
    for (int i = 7; i >= 0; i--) begin
      if (keys[i]) t = 4'(i + 1);
    end
    return t;
  endfunction

  // Strike count for a 24-hour value: hour mod 12, with 0 striking 12.
  function automatic logic [3:0] beep_count(input logic [6:0] hour);
    logic [3:0] m;
    m = 4'(hour % 7'd12);
    return (m == 4'd0) ? 4'd12 : m;
  endfunction

endpackage

// File: rtl/bell_melody_rom_57.sv
// Combinational lookup of the 8-note alarm melody.
module bell_melody_rom_57 (
  input  logic [2:0] idx,
  output logic [3:0] tone
);
  import bell_pkg_57::*;

  always_comb begin
    tone = MELODY_57[{idx, 2'b00} +: 4];
  end

endmodule

// File: rtl/bell_sched_57.sv
// Buzzer arbiter: organ keys preempt the alarm melody, which preempts the hourly
// chime. Collided requests are pended or dropped; tone and source are registered.
module bell_sched_57 #(
  parameter int         NOTE_MS         = 250,
  parameter int         ALARM_TIMEOUT_S = 60,
  parameter int         BEEP_ON_MS      = 200,
  parameter int         BEEP_OFF_MS     = 300,
  parameter logic [3:0] CHIME_TONE      = 4'd6
) (
  input  logic       clk_50m_57,
  input  logic       rst_57,
  input  logic       tick_1k_57,
  input  logic       tick_1hz_57,
  input  logic       bell_e_57,
  input  logic       organ_e_57,
  input  logic [7:0] organ_key_57,
  input  logic       alarm_hit_57,
  input  logic       chime_hit_57,
  input  logic [6:0] hour_57,
  input  logic       key_stop_57,
  output logic [3:0] tone_sel_57,
  output logic [1:0] src_57
);
  import bell_pkg_57::*;

  localparam logic [8:0] NOTE_LAST     = 9'(NOTE_MS - 1);
  localparam logic [8:0] BEEP_ON_LAST  = 9'(BEEP_ON_MS - 1);
  localparam logic [8:0] BEEP_OFF_LAST = 9'(BEEP_OFF_MS - 1);
  localparam logic [5:0] SEC_LAST      = 6'(ALARM_TIMEOUT_S - 1);

  bell_state_t state_reg, state_next;
  logic [8:0]  ms_reg, ms_next;
  logic [5:0]  sec_reg, sec_next;
  logic [3:0]  beep_reg, beep_next;
  logic [2:0]  note_reg, note_next;
  logic        alarm_pend_reg, alarm_pend_next;
  logic        chime_pend_reg, chime_pend_next;
  logic [6:0]  hour_reg, hour_next;
  logic [3:0]  tone_reg, tone_next;
  logic [1:0]  src_reg, src_next;

  logic        go_alarm, go_chime, go_idle;
  logic        chime_req;
  logic        chime_active;
  logic [6:0]  hour_eff;
  logic [3:0]  melody_tone;

  bell_melody_rom_57 u_rom (
    .idx  (note_next),
    .tone (melody_tone)
  );

  // A chime hit in this very cycle counts as pending and carries the fresh hour.
  assign chime_req    = chime_pend_reg | chime_hit_57;
  assign hour_eff     = chime_hit_57 ? hour_57 : hour_reg;
  assign chime_active = (state_reg == ST_CHIME_ON) || (state_reg == ST_CHIME_OFF);

  always_comb begin
    state_next      = state_reg;
    ms_next         = ms_reg;
    sec_next        = sec_reg;
    beep_next       = beep_reg;
    note_next       = note_reg;
    alarm_pend_next = alarm_pend_reg;
    chime_pend_next = chime_pend_reg;
    hour_next       = hour_reg;
    go_alarm        = 1'b0;
    go_chime        = 1'b0;
    go_idle         = 1'b0;

    if (!bell_e_57) begin
      state_next      = ST_IDLE;
      ms_next         = '0;
      sec_next        = '0;
      beep_next       = '0;
      note_next       = '0;
      alarm_pend_next = 1'b0;
      chime_pend_next = 1'b0;
      hour_next       = '0;
    end else if (organ_e_57) begin
      // Preempted alarm/chime is pended and will replay from its start.
      state_next = ST_ORGAN;
      ms_next    = '0;
      sec_next   = '0;
      beep_next  = '0;
      note_next  = '0;
      if (state_reg == ST_ALARM || alarm_hit_57) alarm_pend_next = 1'b1;
      if (chime_active || chime_hit_57)          chime_pend_next = 1'b1;
      if (chime_hit_57 && !chime_active)         hour_next       = hour_57;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (alarm_hit_57) begin
            go_alarm = 1'b1;
            if (chime_hit_57) begin
              chime_pend_next = 1'b1;
              hour_next       = hour_57;
            end
          end else if (chime_hit_57) begin
            go_chime = 1'b1;
          end
        end

        ST_ORGAN: begin
          if (alarm_pend_reg || alarm_hit_57) begin
            go_alarm = 1'b1;
            if (chime_hit_57) begin
              chime_pend_next = 1'b1;
              hour_next       = hour_57;
            end
          end else if (chime_req) begin
            go_chime = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end

        ST_ALARM: begin
          if (key_stop_57 || (tick_1hz_57 && sec_reg == SEC_LAST)) begin
            if (chime_req) go_chime = 1'b1;
            else           go_idle  = 1'b1;
          end else begin
            if (tick_1k_57) begin
              if (ms_reg == NOTE_LAST) begin
                ms_next   = '0;
                note_next = note_reg + 3'd1;
              end else begin
                ms_next = ms_reg + 9'd1;
              end
            end
            if (alarm_hit_57)     sec_next = '0;
            else if (tick_1hz_57) sec_next = sec_reg + 6'd1;
            if (chime_hit_57) begin
              chime_pend_next = 1'b1;
              hour_next       = hour_57;
            end
          end
        end

        ST_CHIME_ON: begin
          if (key_stop_57) begin
            go_idle = 1'b1;
          end else if (alarm_hit_57) begin
            go_alarm = 1'b1;
          end else if (tick_1k_57) begin
            if (ms_reg == BEEP_ON_LAST) begin
              state_next = ST_CHIME_OFF;
              ms_next    = '0;
            end else begin
              ms_next = ms_reg + 9'd1;
            end
          end
        end

        ST_CHIME_OFF: begin
          if (key_stop_57) begin
            go_idle = 1'b1;
          end else if (alarm_hit_57) begin
            go_alarm = 1'b1;
          end else if (tick_1k_57) begin
            if (ms_reg == BEEP_OFF_LAST) begin
              ms_next = '0;
              if (beep_reg <= 4'd1) begin
                go_idle = 1'b1;
              end else begin
                state_next = ST_CHIME_ON;
                beep_next  = beep_reg - 4'd1;
              end
            end else begin
              ms_next = ms_reg + 9'd1;
            end
          end
        end

        default: go_idle = 1'b1;
      endcase

      // Entry actions; any tick on the entry cycle is swallowed by the clears.
      if (go_alarm) begin
        state_next      = ST_ALARM;
        ms_next         = '0;
        sec_next        = '0;
        note_next       = '0;
        alarm_pend_next = 1'b0;
      end else if (go_chime) begin
        state_next      = ST_CHIME_ON;
        ms_next         = '0;
        beep_next       = beep_count(hour_eff);
        hour_next       = hour_eff;
        chime_pend_next = 1'b0;
      end else if (go_idle) begin
        state_next = ST_IDLE;
        ms_next    = '0;
        sec_next   = '0;
        beep_next  = '0;
        note_next  = '0;
      end
    end
  end

  always_comb begin
    tone_next = TONE_OFF;
    src_next  = SRC_NONE;
    unique case (state_next)
      ST_ORGAN: begin
        tone_next = organ_tone(organ_key_57);
        src_next  = SRC_ORGAN;
      end
      ST_ALARM: begin
        tone_next = melody_tone;
        src_next  = SRC_ALARM;
      end
      ST_CHIME_ON: begin
        tone_next = CHIME_TONE;
        src_next  = SRC_CHIME;
      end
      ST_CHIME_OFF: begin
        src_next = SRC_CHIME;
      end
      default: begin
        tone_next = TONE_OFF;
        src_next  = SRC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_50m_57 or negedge rst_57) begin
    if (!rst_57) begin
      state_reg      <= ST_IDLE;
      ms_reg         <= '0;
      sec_reg        <= '0;
      beep_reg       <= '0;
      note_reg       <= '0;
      alarm_pend_reg <= 1'b0;
      chime_pend_reg <= 1'b0;
      hour_reg       <= '0;
      tone_reg       <= TONE_OFF;
      src_reg        <= SRC_NONE;
    end else begin
      state_reg      <= state_next;
      ms_reg         <= ms_next;
      sec_reg        <= sec_next;
      beep_reg       <= beep_next;
      note_reg       <= note_next;
      alarm_pend_reg <= alarm_pend_next;
      chime_pend_reg <= chime_pend_next;
      hour_reg       <= hour_next;
      tone_reg       <= tone_next;
      src_reg        <= src_next;
    end
  end

  assign tone_sel_57 = tone_reg;
  assign src_57      = src_reg;

endmodule

// File: tb/tb_bell_sched_57.sv
// Directed bench for bell_sched_57: melody/timeout, chime counts, collisions,
// organ preemption, master mute and asynchronous reset.
module tb_bell_sched_57;

  logic       clk_50m_57   = 1'b0;
  logic       rst_57       = 1'b0;
  logic       tick_1k_57   = 1'b0;
  logic       tick_1hz_57  = 1'b0;
  logic       bell_e_57    = 1'b1;
  logic       organ_e_57   = 1'b0;
  logic [7:0] organ_key_57 = 8'd0;
  logic       alarm_hit_57 = 1'b0;
  logic       chime_hit_57 = 1'b0;
  logic [6:0] hour_57      = 7'd0;
  logic       key_stop_57  = 1'b0;
  logic [3:0] tone_sel_57;
  logic [1:0] src_57;

  int checks   = 0;
  int failures = 0;
  int mel [8]  = '{1, 3, 5, 8, 5, 3, 1, 0};

  bell_sched_57 dut (
    .clk_50m_57   (clk_50m_57),
    .rst_57       (rst_57),
    .tick_1k_57   (tick_1k_57),
    .tick_1hz_57  (tick_1hz_57),
    .bell_e_57    (bell_e_57),
    .organ_e_57   (organ_e_57),
    .organ_key_57 (organ_key_57),
    .alarm_hit_57 (alarm_hit_57),
    .chime_hit_57 (chime_hit_57),
    .hour_57      (hour_57),
    .key_stop_57  (key_stop_57),
    .tone_sel_57  (tone_sel_57),
    .src_57       (src_57)
  );

  always #5 clk_50m_57 = ~clk_50m_57;

  task automatic cyc();
    @(posedge clk_50m_57);
    #1;
  endtask

  task automatic chk(input string tag, input int t_exp, input int s_exp);
    logic [5:0] obs, exp_v;
    obs   = {tone_sel_57, src_57};
    exp_v = {4'(t_exp), 2'(s_exp)};
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: tone=%0d src=%0d, expected tone=%0d src=%0d",
             tag, tone_sel_57, src_57, t_exp, s_exp);
    end
  endtask

  task automatic ms_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1k_57 = 1'b1; cyc();
      tick_1k_57 = 1'b0; cyc();
    end
  endtask

  task automatic hz_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz_57 = 1'b1; cyc();
      tick_1hz_57 = 1'b0; cyc();
    end
  endtask

  task automatic pulse(input logic a, input logic c, input logic k);
    alarm_hit_57 = a; chime_hit_57 = c; key_stop_57 = k;
    cyc();
    alarm_hit_57 = 1'b0; chime_hit_57 = 1'b0; key_stop_57 = 1'b0;
  endtask

  // Assumes the chime has just started (first beep on, zero ticks counted).
  task automatic run_chime(input string tag, input int n);
    for (int b = 1; b <= n; b++) begin
      ms_ticks(199); chk({tag, "_on_hold"}, 6, 3);
      ms_ticks(1);   chk({tag, "_gap"}, 0, 3);
      ms_ticks(299); chk({tag, "_gap_hold"}, 0, 3);
      ms_ticks(1);
      if (b == n) chk({tag, "_done"}, 0, 0);
      else        chk({tag, "_next_on"}, 6, 3);
    end
  endtask

  initial begin
    // Reset state
    #1 chk("reset_hold", 0, 0);
    cyc(); cyc();
    rst_57 = 1'b1;
    cyc(); chk("idle_after_reset", 0, 0);

    // Alarm melody, then 60-second timeout
    pulse(1'b1, 1'b0, 1'b0); chk("alarm_start", 1, 2);
    for (int k = 0; k < 9; k++) begin
      ms_ticks(249); chk("note_hold", mel[k % 8], 2);
      ms_ticks(1);   chk("note_adv", mel[(k + 1) % 8], 2);
    end
    hz_ticks(59); chk("alarm_59s", 3, 2);
    hz_ticks(1);  chk("alarm_timeout", 0, 0);

    // Alarm re-hit restarts the timeout
    pulse(1'b1, 1'b0, 1'b0); chk("alarm2_start", 1, 2);
    hz_ticks(30);
    pulse(1'b1, 1'b0, 1'b0); chk("alarm2_rehit", 1, 2);
    hz_ticks(59); chk("alarm2_59s", 1, 2);
    hz_ticks(1);  chk("alarm2_timeout", 0, 0);

    // Chime counts
    hour_57 = 7'd0;  pulse(1'b0, 1'b1, 1'b0); chk("chime0_start", 6, 3);
    run_chime("chime_h0", 12);
    hour_57 = 7'd12; pulse(1'b0, 1'b1, 1'b0); chk("chime12_start", 6, 3);
    run_chime("chime_h12", 12);
    hour_57 = 7'd15; pulse(1'b0, 1'b1, 1'b0); chk("chime15_start", 6, 3);
    run_chime("chime_h15", 3);

    // Simultaneous alarm and chime, stop after 5 s, pended chime of 9 beeps
    hour_57 = 7'd9; pulse(1'b1, 1'b1, 1'b0); chk("coll_alarm", 1, 2);
    hour_57 = 7'd3;
    hz_ticks(5); chk("coll_5s", 1, 2);
    pulse(1'b0, 1'b0, 1'b1); chk("coll_chime_start", 6, 3);
    run_chime("coll_chime", 9);

    // Stop wins over a restarting alarm hit
    pulse(1'b1, 1'b0, 1'b0); chk("stopwin_start", 1, 2);
    pulse(1'b1, 1'b0, 1'b1); chk("stopwin_idle", 0, 0);

    // Organ preemption, alarm replays from its first note
    pulse(1'b1, 1'b0, 1'b0); chk("pre_alarm", 1, 2);
    ms_ticks(250); chk("pre_alarm_n1", 3, 2);
    organ_e_57 = 1'b1; organ_key_57 = 8'b0010_0100;
    cyc(); chk("organ_key", 3, 1);
    organ_key_57 = 8'b1000_0000; cyc(); chk("organ_doh", 8, 1);
    organ_key_57 = 8'b0000_0000; cyc(); chk("organ_nokey", 0, 1);
    organ_e_57 = 1'b0;
    cyc(); chk("organ_resume", 1, 2);
    pulse(1'b0, 1'b0, 1'b1); chk("organ_stop", 0, 0);

    // Master mute mid-chime
    hour_57 = 7'd2; pulse(1'b0, 1'b1, 1'b0); chk("mute_chime", 6, 3);
    ms_ticks(100);
    bell_e_57 = 1'b0; cyc(); chk("mute_off", 0, 0);
    pulse(1'b1, 1'b0, 1'b0); chk("mute_hit", 0, 0);
    bell_e_57 = 1'b1; cyc(); chk("mute_back", 0, 0);
    ms_ticks(600); chk("mute_silent", 0, 0);

    // Asynchronous reset between edges
    pulse(1'b1, 1'b0, 1'b0); chk("rst_alarm", 1, 2);
    #2 rst_57 = 1'b0;
    #1 chk("rst_async", 0, 0);
    #2 rst_57 = 1'b1;
    cyc(); chk("rst_release", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
